// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, NOP encoding,
// PC increment and FSM state encoding.
// Latency: n/a (package). Backpressure: n/a (package).
package fetch_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_INC = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer: push/pop/flush, head presented combinationally from storage.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop frees a slot in the same cycle.
//
// Ports: clk/reset (async active-low), push+push_dat write, pop retires head,
// flush empties the buffer (wins over push/pop), head_dat/count/empty status.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 42
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               push_dat,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch control: drives the PC, issues imem reads, buffers returned words for decode.
// Latency: 2 cycles from issue of a PC to if_valid (issue, then capture); 1 instr/cycle sustained.
// Backpressure: decode stalls via if_ready=0; issue stops once buffered + in-flight words fill the FIFO.
//
// Ports: clk, reset (async active-low); fetch_en gates issue; current_pc/next_pc/PCWrite close
// the PC loop; imem_en/imem_addr/imem_rdata talk to a 1-cycle synchronous memory;
// redirect_valid/redirect_pc flush everything in flight; if_valid/if_ready/if_pc/if_instr to decode.
module fetch_unit #(
  parameter int                ADDR_W     = fetch_pkg::ADDR_W,
  parameter int                DATA_W     = fetch_pkg::DATA_W,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [DATA_W-1:0] NOP_INSTR  = DATA_W'(fetch_pkg::NOP_INSTR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] current_pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              PCWrite,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr
);

  import fetch_pkg::fetch_state_e;
  import fetch_pkg::S_IDLE;
  import fetch_pkg::S_FETCH;
  import fetch_pkg::PC_INC;

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  fetch_state_e  state;
  logic          inflight;
  logic [ADDR_W-1:0] pc_tag;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          pop;
  logic          issue;
  logic [CW:0]   occupancy;

  // A redirect hides the head so decode never consumes a word from the wrong path.
  assign if_valid = !fifo_empty && !redirect_valid;
  assign pop      = if_valid && if_ready;
  assign if_pc    = if_valid ? head_entry.pc : '0;
  assign if_instr = if_valid ? head_entry.instr : NOP_INSTR;

  // Slots already claimed once this cycle's pop and pending response are accounted for;
  // issuing only below depth guarantees the response always has room the next cycle.
  assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue     = (state == S_FETCH) && !redirect_valid &&
                     (occupancy < (CW+1)'(FIFO_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = issue ? current_pc : '0;

  always_comb begin
    PCWrite = 1'b0;
    next_pc = current_pc;
    if (redirect_valid) begin
      PCWrite = 1'b1;
      next_pc = redirect_pc;
    end else if (issue) begin
      PCWrite = 1'b1;
      next_pc = current_pc + ADDR_W'(PC_INC);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      inflight <= 1'b0;
      pc_tag   <= '0;
    end else begin
      case (state)
        S_IDLE:  if (fetch_en)  state <= S_FETCH;
        S_FETCH: if (!fetch_en) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // issue is already low during a redirect, which drops the pending response.
      inflight <= issue;
      if (issue) pc_tag <= current_pc;
    end
  end

  assign push_entry.pc    = pc_tag;
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .pop      (pop),
    .flush    (redirect_valid),
    .push_dat (push_entry),
    .head_dat (head_entry),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic          if_ready = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] current_pc;
  logic [AW-1:0] next_pc;
  logic [AW-1:0] imem_addr;
  logic [AW-1:0] if_pc;
  logic          PCWrite;
  logic          imem_en;
  logic          if_valid;
  logic [DW-1:0] imem_rdata = '0;
  logic [DW-1:0] if_instr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .current_pc     (current_pc),
    .next_pc        (next_pc),
    .PCWrite        (PCWrite),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  // Memory contents: address repeated in both halves (word at 0 is 0, distinct from pc elsewhere).
  function automatic logic [31:0] word_of(input logic [9:0] a);
    return {6'd0, a, 6'd0, a};
  endfunction

  // Environment: PC register and 1-cycle synchronous instruction memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) current_pc <= '0;
    else if (PCWrite) current_pc <= next_pc;
  end

  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= word_of(imem_addr);
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          fe, rdy, rv;
    logic [AW-1:0] rpc;
    logic          e_en;
    logic [AW-1:0] e_addr;
    logic          e_pcw;
    logic [AW-1:0] e_npc;
    logic          e_vld;
    logic [AW-1:0] e_pc;
  } vec_t;

  vec_t vt[25];

  initial begin
    logic [95:0]   act;
    logic [95:0]   exp;
    logic [31:0]   e_instr;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] pc_plus;
    int            run;
    int            delivered;

    // fe rdy rv rpc      | en addr pcw npc vld pc
    vt[0]  = '{T,T,F,10'h000, F,10'h000,F,10'h000,F,10'h000};
    vt[1]  = '{T,T,F,10'h000, T,10'h000,T,10'h004,F,10'h000};
    vt[2]  = '{T,T,F,10'h000, T,10'h004,T,10'h008,F,10'h000};
    vt[3]  = '{T,T,F,10'h000, T,10'h008,T,10'h00C,T,10'h000};
    vt[4]  = '{T,T,F,10'h000, T,10'h00C,T,10'h010,T,10'h004};
    vt[5]  = '{T,F,F,10'h000, F,10'h000,F,10'h010,T,10'h008};
    vt[6]  = '{T,F,F,10'h000, F,10'h000,F,10'h010,T,10'h008};
    vt[7]  = '{T,F,F,10'h000, F,10'h000,F,10'h010,T,10'h008};
    vt[8]  = '{T,T,F,10'h000, T,10'h010,T,10'h014,T,10'h008};
    vt[9]  = '{T,T,F,10'h000, T,10'h014,T,10'h018,T,10'h00C};
    vt[10] = '{T,T,F,10'h000, T,10'h018,T,10'h01C,T,10'h010};
    vt[11] = '{T,T,T,10'h100, F,10'h000,T,10'h100,F,10'h000};
    vt[12] = '{T,T,F,10'h000, T,10'h100,T,10'h104,F,10'h000};
    vt[13] = '{T,T,F,10'h000, T,10'h104,T,10'h108,F,10'h000};
    vt[14] = '{T,T,F,10'h000, T,10'h108,T,10'h10C,T,10'h100};
    vt[15] = '{F,T,F,10'h000, T,10'h10C,T,10'h110,T,10'h104};
    vt[16] = '{F,T,F,10'h000, F,10'h000,F,10'h110,T,10'h108};
    vt[17] = '{F,T,F,10'h000, F,10'h000,F,10'h110,T,10'h10C};
    vt[18] = '{F,T,F,10'h000, F,10'h000,F,10'h110,F,10'h000};
    vt[19] = '{T,T,T,10'h3F8, F,10'h000,T,10'h3F8,F,10'h000};
    vt[20] = '{T,T,F,10'h000, T,10'h3F8,T,10'h3FC,F,10'h000};
    vt[21] = '{T,T,F,10'h000, T,10'h3FC,T,10'h000,F,10'h000};
    vt[22] = '{T,T,F,10'h000, T,10'h000,T,10'h004,T,10'h3F8};
    vt[23] = '{T,T,F,10'h000, T,10'h004,T,10'h008,T,10'h3FC};
    vt[24] = '{T,T,F,10'h000, T,10'h008,T,10'h00C,T,10'h000};

    // Reset state, with fetch requested so reset alone must hold everything off.
    fetch_en = 1'b1;
    if_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pcwrite", PCWrite, 1'b0);
    check("rst_next_pc", next_pc, 10'h000);
    check("rst_imem", {imem_en, imem_addr}, {1'b0, 10'h000});
    check("rst_if", {if_valid, if_pc, if_instr}, {1'b0, 10'h000, NOP});

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      reset          = 1'b1;
      fetch_en       = vt[i].fe;
      if_ready       = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
      #1;
      e_instr = vt[i].e_vld ? word_of(vt[i].e_pc) : NOP;
      act = {imem_en, imem_addr, PCWrite, next_pc, if_valid, if_pc, if_instr};
      exp = {vt[i].e_en, vt[i].e_addr, vt[i].e_pcw, vt[i].e_npc, vt[i].e_vld, vt[i].e_pc, e_instr};
      check($sformatf("row%0d", i), act, exp);
    end

    // Async reset between edges while a word is held: everything drops at once.
    @(negedge clk);
    redirect_valid = 1'b0;
    fetch_en = 1'b1;
    if_ready = 1'b0;
    #1;
    check("pre_rst_valid", {if_valid, if_pc}, {1'b1, 10'h004});
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", {if_valid, PCWrite, imem_en, if_instr}, {1'b0, 1'b0, 1'b0, NOP});
    @(negedge clk);
    fetch_en = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_rst_empty%0d", i), {if_valid, imem_en, PCWrite}, {1'b0, 1'b0, 1'b0});
    end

    // Randomized run against an instruction-stream model: decode must see consecutive
    // word addresses, restarting at each redirect target, each carrying its memory word.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fetch_en = 1'b1;
    exp_pc = '0;
    run = 0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) fetch_en = ~fetch_en;
      if ($urandom_range(0, 2) == 0)  if_ready = ~if_ready;
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = AW'($urandom_range(0, 255)) << 2;
      #1;
      pc_plus = current_pc + 10'd4;
      if (redirect_valid)
        check("rnd_redirect", {PCWrite, next_pc, imem_en, if_valid}, {1'b1, redirect_pc, 1'b0, 1'b0});
      else if (imem_en)
        check("rnd_issue", {imem_addr, PCWrite, next_pc}, {current_pc, 1'b1, pc_plus});
      else
        check("rnd_hold", {PCWrite, next_pc, imem_addr}, {1'b0, current_pc, 10'h000});
      if (!if_valid)
        check("rnd_empty_out", {if_pc, if_instr}, {10'h000, NOP});
      if (if_valid && if_ready) begin
        check("rnd_order", {if_pc, if_instr}, {exp_pc, word_of(exp_pc)});
        exp_pc = exp_pc + 10'd4;
        delivered++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      run = (fetch_en && if_ready && !redirect_valid) ? run + 1 : 0;
      if (run >= 4) check("rnd_live", if_valid, 1'b1);
    end
    check("rnd_progress", (delivered > 500), 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
